// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader and the processor
// around it: memory geometry defaults, the loader state encoding and a helper
// that decides whether a requested word count can be loaded.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    // Instruction-memory geometry defaults.
    localparam int IMEM_BYTES_DEF = 512;
    localparam int MAX_WORDS_DEF  = IMEM_BYTES_DEF / 4;
    localparam int IMEM_ADDR_W    = $clog2(IMEM_BYTES_DEF);

    // Loader session states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } loader_state_e;

    // A session length is usable when it is non-zero and fits the limit.
    function automatic logic len_ok(input logic [7:0] len, input int limit);
        return (len != 8'd0) && (int'(len) <= limit);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader's control, serial byte stream, instruction-memory write
// port and processor-control signals.
//   master : host side (drives load_start/load_len/byte_in/byte_valid,
//            observes everything else)
//   slave  : loader side
// Signals:
//   load_start  one-cycle pulse starting a session
//   load_len    word count sampled with load_start
//   byte_in / byte_valid / byte_ready   serial byte handshake
//   mem_we / mem_addr / mem_wdata       instruction-memory write port
//   cpu_hold    processor held in reset while high
//   busy        session in progress
//   load_done   one-cycle success pulse
//   load_err    sticky error flag
// -----------------------------------------------------------------------------
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);
    logic              load_start;
    logic [7:0]        load_len;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              load_done;
    logic              load_err;

    modport master (
        output load_start, load_len, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata,
               cpu_hold, busy, load_done, load_err
    );

    modport slave (
        input  load_start, load_len, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata,
               cpu_hold, busy, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a program as a serial byte stream, packs it big-endian into 32-bit
// words, writes each word into instruction memory and verifies a trailing
// checksum byte (sum of all bytes plus trailer must be 0 mod 256). The
// processor is held in reset (cpu_hold) until a session completes cleanly.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    imem_loader_if.slave (control, byte stream, memory write port,
//          cpu_hold/busy/load_done/load_err status)
// All outputs are registered.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_BYTES = IMEM_BYTES_DEF,
    parameter int MAX_WORDS  = MAX_WORDS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

    // The usable word limit is also clipped to the memory size, so the
    // highest address ever written is IMEM_BYTES-4.
    localparam int WORD_LIMIT = (MAX_WORDS < IMEM_BYTES / 4) ? MAX_WORDS : IMEM_BYTES / 4;

    loader_state_e           state_q;
    logic [7:0]              len_q;
    logic [7:0]              word_cnt_q;
    logic [1:0]              byte_cnt_q;
    logic [7:0]              checksum_q;
    logic [23:0]             shift_q;      // first three bytes of the current word
    logic                    byte_ready_q;
    logic                    mem_we_q;
    logic [IMEM_ADDR_W-1:0]  mem_addr_q;
    logic [31:0]             mem_wdata_q;
    logic                    cpu_hold_q;
    logic                    busy_q;
    logic                    load_done_q;
    logic                    load_err_q;

    logic                    byte_fire;
    logic [31:0]             shift_d;
    logic [7:0]              checksum_d;
    logic [7:0]              word_cnt_d;

    always_comb begin
        byte_fire  = bus.byte_valid && byte_ready_q;
        // Incoming byte lands in the low lane; after four bytes the first
        // byte has moved up to bits 31:24.
        shift_d    = {shift_q, bus.byte_in};
        checksum_d = checksum_q + bus.byte_in;
        word_cnt_d = word_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            checksum_q   <= '0;
            shift_q      <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            mem_we_q    <= 1'b0;
            load_done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        // Any new session clears the previous error and
                        // takes the processor back into reset.
                        load_err_q <= 1'b0;
                        cpu_hold_q <= 1'b1;
                        len_q      <= bus.load_len;
                        word_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        checksum_q <= '0;
                        if (len_ok(bus.load_len, WORD_LIMIT)) begin
                            state_q      <= ST_RECV;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                        end
                    end
                end

                ST_RECV: begin
                    if (byte_fire) begin
                        shift_q    <= shift_d[23:0];
                        checksum_q <= checksum_d;
                        if (byte_cnt_q == 2'd3) begin
                            byte_cnt_q   <= '0;
                            state_q      <= ST_WRITE;
                            byte_ready_q <= 1'b0;
                            mem_we_q     <= 1'b1;
                            mem_addr_q   <= IMEM_ADDR_W'({word_cnt_q, 2'b00});
                            mem_wdata_q  <= shift_d;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end

                ST_WRITE: begin
                    word_cnt_q   <= word_cnt_d;
                    byte_ready_q <= 1'b1;
                    state_q      <= (word_cnt_d == len_q) ? ST_CHECK : ST_RECV;
                end

                ST_CHECK: begin
                    // The trailer only feeds the checksum test; it is never
                    // written to memory.
                    if (byte_fire) begin
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        if (checksum_d == 8'd0) begin
                            state_q     <= ST_DONE;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                        end
                    end
                end

                ST_DONE: begin
                    // Release the processor the cycle after load_done.
                    cpu_hold_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end

                ST_ERR: begin
                    // cpu_hold is left asserted: a failed image must not run.
                    load_err_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end

                default: begin
                    state_q      <= ST_IDLE;
                    byte_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.busy       = busy_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed sessions against imem_loader. The driver pushes the expected memory
// writes and completion events into a scoreboard queue; a monitor on the
// falling edge pops and compares whenever the loader writes memory, pulses
// load_done or raises load_err. Expected checksum trailers are hand-computed:
//   12+34+56+78 = 0x114 -> 0x14, good trailer 0xEC (0xC8 and 0x00 are bad)
//   00 00 00 01 00 00 00 02 -> 0x03, good trailer 0xFD
// -----------------------------------------------------------------------------
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int K_WR   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [8:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader #(
        .IMEM_BYTES (512),
        .MAX_WORDS  (128)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   st_cyc = 0;
    logic err_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push(input int k, input logic [8:0] a, input logic [31:0] d);
        sb.push_back('{kind: k, addr: a, data: d});
    endfunction

    function automatic void take(input int k, input logic [8:0] a, input logic [31:0] d);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind=%0d addr=0x%0h data=0x%08h, expected nothing", k, a, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || (k == K_WR && (e.addr !== a || e.data !== d))) begin
                errors++;
                $display("FAIL sb_event: got kind=%0d addr=0x%0h data=0x%08h, expected kind=%0d addr=0x%0h data=0x%08h",
                         k, a, d, e.kind, e.addr, e.data);
            end else begin
                $display("[sb] t=%0t kind=%0d addr=0x%0h data=0x%08h ok", $time, k, a, d);
            end
        end
    endfunction

    // Monitor: every DUT-presented event is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_we)                  take(K_WR, bus.mem_addr, bus.mem_wdata);
            if (bus.load_done)               take(K_DONE, 9'd0, 32'd0);
            if (bus.load_err && !err_prev)   take(K_ERR, 9'd0, 32'd0);
        end
        err_prev <= bus.load_err;
    end

    task automatic check_reset_vals(input string name);
        chk(name, {bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                   bus.cpu_hold, bus.busy, bus.load_done, bus.load_err},
                  {1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic start(input logic [7:0] len);
        bus.load_len   = len;
        bus.load_start = 1'b1;
        @(posedge clk);
        #1;
        st_cyc         = cyc;
        bus.load_start = 1'b0;
    endtask

    // Offer one byte (optionally after one idle cycle) until it is accepted.
    task automatic send(input logic [7:0] b, input bit gap);
        bit rdy;
        bit ok;
        ok = 1'b0;
        if (gap) begin
            bus.byte_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            rdy = bus.byte_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        bus.byte_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte 0x%02h not accepted, expected acceptance", b);
        end
    endtask

    // Wait (bounded) for load_done or load_err; latency counted from start.
    task automatic wait_sig(input bit want_done, input string name, output int lat);
        bit found;
        found = 1'b0;
        lat   = -1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (want_done ? bus.load_done : bus.load_err) begin
                found = 1'b1;
                lat   = cyc - st_cyc;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: event not seen, expected within 100 cycles", name);
        end
    endtask

    task automatic send_word_set(input logic [31:0] w, input bit gap);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], gap);
    endtask

    task automatic sb_drained(input string name);
        repeat (3) @(negedge clk);
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int lat;
        bit seen;
        bus.load_start = 1'b0;
        bus.load_len   = 8'd0;
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_state");

        // Single word, good trailer: minimum latency 4+1+1 trailer = 6.
        push(K_WR, 9'd0, 32'h12345678);
        push(K_DONE, 9'd0, 32'd0);
        start(8'd1);
        send_word_set(32'h12345678, 1'b0);
        send(8'hEC, 1'b0);
        wait_sig(1'b1, "t1_done", lat);
        chk("t1_latency", 64'(lat), 64'd6);
        chk("t1_hold_at_done", 64'(bus.cpu_hold), 64'd1);
        @(negedge clk);
        chk("t1_hold_released", 64'(bus.cpu_hold), 64'd0);
        chk("t1_busy_idle", 64'(bus.busy), 64'd0);
        sb_drained("t1_sb_empty");

        // Same word, bad trailers: error, no done, processor kept in reset.
        push(K_WR, 9'd0, 32'h12345678);
        push(K_ERR, 9'd0, 32'd0);
        start(8'd1);
        chk("t3_hold_reasserted", 64'(bus.cpu_hold), 64'd1);
        send_word_set(32'h12345678, 1'b0);
        send(8'h00, 1'b0);
        wait_sig(1'b0, "t3_err", lat);
        repeat (3) @(negedge clk);
        chk("t3_err_sticky", 64'(bus.load_err), 64'd1);
        chk("t3_hold_kept", 64'(bus.cpu_hold), 64'd1);
        sb_drained("t3_sb_empty");

        push(K_WR, 9'd0, 32'h12345678);
        push(K_ERR, 9'd0, 32'd0);
        start(8'd1);
        send_word_set(32'h12345678, 1'b0);
        send(8'hC8, 1'b0);
        wait_sig(1'b0, "t3b_err", lat);
        sb_drained("t3b_sb_empty");

        // Two words, good trailer: 2*(4+1)+1 = 11 cycles to load_done.
        push(K_WR, 9'd0, 32'h00000001);
        push(K_WR, 9'd4, 32'h00000002);
        push(K_DONE, 9'd0, 32'd0);
        start(8'd2);
        chk("t2_err_cleared", 64'(bus.load_err), 64'd0);
        send_word_set(32'h00000001, 1'b0);
        send_word_set(32'h00000002, 1'b0);
        send(8'hFD, 1'b0);
        wait_sig(1'b1, "t2_done", lat);
        chk("t2_latency", 64'(lat), 64'd11);
        sb_drained("t2_sb_empty");

        // Out-of-range lengths: immediate error, bytes never accepted.
        push(K_ERR, 9'd0, 32'd0);
        start(8'd0);
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hAA;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.byte_ready || bus.busy) seen = 1'b1;
        end
        bus.byte_valid = 1'b0;
        chk("len0_no_ready", 64'(seen), 64'd0);
        chk("len0_err", 64'(bus.load_err), 64'd1);
        sb_drained("len0_sb_empty");

        push(K_ERR, 9'd0, 32'd0);
        start(8'd129);
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h55;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.byte_ready || bus.busy) seen = 1'b1;
        end
        bus.byte_valid = 1'b0;
        chk("len129_no_ready", 64'(seen), 64'd0);
        chk("len129_err", 64'(bus.load_err), 64'd1);
        sb_drained("len129_sb_empty");

        // Two words with byte_valid toggling and a stray load_start mid-session.
        push(K_WR, 9'd0, 32'h00000001);
        push(K_WR, 9'd4, 32'h00000002);
        push(K_DONE, 9'd0, 32'd0);
        start(8'd2);
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        bus.load_len   = 8'd7;
        bus.load_start = 1'b1;
        @(posedge clk);
        #1 bus.load_start = 1'b0;
        chk("t5_busy_kept", 64'(bus.busy), 64'd1);
        send(8'h00, 1'b1);
        send(8'h01, 1'b1);
        send_word_set(32'h00000002, 1'b1);
        send(8'hFD, 1'b1);
        wait_sig(1'b1, "t5_done", lat);
        chk("t5_latency_stretched", 64'(lat > 11), 64'd1);
        sb_drained("t5_sb_empty");

        // Reset after six bytes: only word 0 reaches memory.
        push(K_WR, 9'd0, 32'h00000001);
        start(8'd2);
        send_word_set(32'h00000001, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("t6_after_reset");
        repeat (8) @(negedge clk);
        chk("t6_no_more_writes", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
